alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit_pkg.sv | 38 +++
 rtl/alu_exec_unit_alu_core.sv | 27 ++
 rtl/alu_exec_unit.sv | 79 +++++++
 tb/tb_alu_exec_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared constants and types for the execute-stage ALU slice:
// control codes, main-control op classes, R-type funct codes.
package alu_exec_unit_pkg;

    typedef logic [31:0] word_t;
    typedef logic [2:0]  alu_ctl_t;

    localparam alu_ctl_t CTL_AND = 3'b000;
    localparam alu_ctl_t CTL_OR  = 3'b001;
    localparam alu_ctl_t CTL_ADD = 3'b010;
    localparam alu_ctl_t CTL_NOR = 3'b100;
    localparam alu_ctl_t CTL_SUB = 3'b110;
    localparam alu_ctl_t CTL_SLT = 3'b111;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        word_t    result;
        logic     zero;
        word_t    branch_addr;
        alu_ctl_t alu_ctl;
    } exec_rsp_t;

    localparam exec_rsp_t EXEC_RSP_RST = '{result: '0, zero: 1'b0, branch_addr: '0, alu_ctl: CTL_ADD};

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Combinational 32-bit ALU: result and zero flag for one control code.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  word_t    a,
    input  word_t    b,
    input  alu_ctl_t ctl,
    output word_t    y,
    output logic     zero
);

    always_comb begin
        y = a + b;
        case (ctl)
            CTL_AND: y = a & b;
            CTL_OR:  y = a | b;
            CTL_ADD: y = a + b;
            CTL_SUB: y = a - b;
            CTL_NOR: y = ~(a | b);
            CTL_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, operand-B mux, branch adder and
// one register stage on all outputs.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_a,
    input  logic [31:0] reg_b,
    input  logic [31:0] imm_ext,
    input  logic        alu_src,
    input  logic [31:0] pc_plus4,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] branch_addr,
    output logic [2:0]  alu_ctl
);

    alu_ctl_t  ctl_d;
    word_t     op_b;
    word_t     alu_y;
    logic      alu_z;
    exec_rsp_t rsp_d, rsp_q;

    // Unknown op classes and unknown functs fall back to ADD.
    always_comb begin
        ctl_d = CTL_ADD;
        case (alu_op)
            ALUOP_ADD: ctl_d = CTL_ADD;
            ALUOP_SUB: ctl_d = CTL_SUB;
            ALUOP_AND: ctl_d = CTL_AND;
            ALUOP_OR:  ctl_d = CTL_OR;
            ALUOP_SLT: ctl_d = CTL_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctl_d = CTL_ADD;
                    FUNCT_SUB: ctl_d = CTL_SUB;
                    FUNCT_AND: ctl_d = CTL_AND;
                    FUNCT_OR:  ctl_d = CTL_OR;
                    FUNCT_NOR: ctl_d = CTL_NOR;
                    FUNCT_SLT: ctl_d = CTL_SLT;
                    default:   ctl_d = CTL_ADD;
                endcase
            end
            default: ctl_d = CTL_ADD;
        endcase
    end

    assign op_b = alu_src ? imm_ext : reg_b;

    alu_core u_alu_core (
        .a    (operand_a),
        .b    (op_b),
        .ctl  (ctl_d),
        .y    (alu_y),
        .zero (alu_z)
    );

    always_comb begin
        rsp_d             = EXEC_RSP_RST;
        rsp_d.result      = alu_y;
        rsp_d.zero        = alu_z;
        rsp_d.branch_addr = pc_plus4 + {imm_ext[29:0], 2'b00};
        rsp_d.alu_ctl     = ctl_d;
    end

    always_ff @(posedge clk) begin
        if (reset) rsp_q <= EXEC_RSP_RST;
        else       rsp_q <= rsp_d;
    end

    assign result      = rsp_q.result;
    assign zero        = rsp_q.zero;
    assign branch_addr = rsp_q.branch_addr;
    assign alu_ctl     = rsp_q.alu_ctl;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + random bench for alu_exec_unit; expected responses are queued
// when stimulus is driven and popped after the clock edge that registers them.
module tb_alu_exec_unit;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [31:0] branch_addr;
        logic [2:0]  alu_ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] operand_a, reg_b, imm_ext, pc_plus4;
    logic        alu_src;
    logic [31:0] result, branch_addr;
    logic        zero;
    logic [2:0]  alu_ctl;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .funct       (funct),
        .operand_a   (operand_a),
        .reg_b       (reg_b),
        .imm_ext     (imm_ext),
        .alu_src     (alu_src),
        .pc_plus4    (pc_plus4),
        .result      (result),
        .zero        (zero),
        .branch_addr (branch_addr),
        .alu_ctl     (alu_ctl)
    );

    // Reference ALU written from the operation table, independent of the RTL.
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] rb,
                                   input logic [31:0] imm, input logic src,
                                   input logic [31:0] pc);
        exp_t        e;
        logic [31:0] b;
        logic [2:0]  c;
        b = src ? imm : rb;
        if      (op == 3'b001) c = 3'b110;
        else if (op == 3'b011) c = 3'b000;
        else if (op == 3'b100) c = 3'b001;
        else if (op == 3'b101) c = 3'b111;
        else if (op == 3'b010 && f == 6'h22) c = 3'b110;
        else if (op == 3'b010 && f == 6'h24) c = 3'b000;
        else if (op == 3'b010 && f == 6'h25) c = 3'b001;
        else if (op == 3'b010 && f == 6'h27) c = 3'b100;
        else if (op == 3'b010 && f == 6'h2a) c = 3'b111;
        else c = 3'b010;
        if      (c == 3'b110) e.result = a - b;
        else if (c == 3'b000) e.result = a & b;
        else if (c == 3'b001) e.result = a | b;
        else if (c == 3'b100) e.result = ~(a | b);
        else if (c == 3'b111) e.result = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
        else e.result = a + b;
        e.zero        = (e.result == 32'd0);
        e.branch_addr = pc + imm * 32'd4;
        e.alu_ctl     = c;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        tests++;
        assert (result === e.result) else begin
            fails++; $error("FAIL %s result got %h exp %h", tag, result, e.result);
        end
        tests++;
        assert (zero === e.zero) else begin
            fails++; $error("FAIL %s zero got %b exp %b", tag, zero, e.zero);
        end
        tests++;
        assert (branch_addr === e.branch_addr) else begin
            fails++; $error("FAIL %s branch_addr got %h exp %h", tag, branch_addr, e.branch_addr);
        end
        tests++;
        assert (alu_ctl === e.alu_ctl) else begin
            fails++; $error("FAIL %s alu_ctl got %b exp %b", tag, alu_ctl, e.alu_ctl);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, pop and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic [2:0] op,
                        input logic [5:0] f, input logic [31:0] a, input logic [31:0] rb,
                        input logic [31:0] imm, input logic src, input logic [31:0] pc,
                        input exp_t e);
        exp_t got_e;
        reset = rst; alu_op = op; funct = f; operand_a = a; reg_b = rb;
        imm_ext = imm; alu_src = src; pc_plus4 = pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s scoreboard empty got 0 exp 1", tag);
        end else begin
            got_e = sb_q.pop_front();
            check(tag, got_e);
        end
    endtask

    localparam exp_t RST = '{result: 32'd0, zero: 1'b0, branch_addr: 32'd0, alu_ctl: 3'b010};

    initial begin
        logic [2:0]  rop;
        logic [5:0]  rf;
        logic [31:0] ra, rb, ri, rp;
        logic        rs;
        reset = 1'b1; alu_op = '0; funct = '0; operand_a = '0; reg_b = '0;
        imm_ext = '0; alu_src = 1'b0; pc_plus4 = '0;
        @(posedge clk); #1;

        step("reset",      1, 3'b010, 6'h20, 32'd5, 32'd6, 32'd1, 0, 32'd100, RST);
        step("rtype_add",  0, 3'b010, 6'h20, 32'd10, 32'd11, 32'd0, 0, 32'd0,
             '{32'd21, 1'b0, 32'd0, 3'b010});
        step("beq_cmp",    0, 3'b001, 6'h00, 32'h12345678, 32'h12345678, 32'd3, 0, 32'd40,
             '{32'd0, 1'b1, 32'd52, 3'b110});
        step("slt_neg",    0, 3'b010, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 32'd0,
             '{32'd1, 1'b0, 32'd0, 3'b111});
        step("slt_swap",   0, 3'b010, 6'h2a, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 32'd0,
             '{32'd0, 1'b1, 32'd0, 3'b111});
        step("ld_wrap",    0, 3'b000, 6'h00, 32'hFFFFFFFC, 32'd0, 32'd8, 1, 32'd0,
             '{32'd4, 1'b0, 32'd32, 3'b010});
        step("br_negimm",  0, 3'b000, 6'h00, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 32'd8,
             '{32'hFFFFFFFF, 1'b0, 32'd4, 3'b010});
        step("fn_and",     0, 3'b010, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 0, 32'd0,
             '{32'h00F000F0, 1'b0, 32'd0, 3'b000});
        step("fn_or",      0, 3'b010, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 0, 32'd0,
             '{32'hFFF0FFF0, 1'b0, 32'd0, 3'b001});
        step("fn_nor",     0, 3'b010, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 0, 32'd0,
             '{32'h000F000F, 1'b0, 32'd0, 3'b100});
        step("fn_sub",     0, 3'b010, 6'h22, 32'd0, 32'd1, 32'd0, 0, 32'd0,
             '{32'hFFFFFFFF, 1'b0, 32'd0, 3'b110});
        step("op_and",     0, 3'b011, 6'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 0, 32'd0,
             '{32'h00F000F0, 1'b0, 32'd0, 3'b000});
        step("op_or",      0, 3'b100, 6'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 0, 32'd0,
             '{32'hFFF0FFF0, 1'b0, 32'd0, 3'b001});
        step("op_slt",     0, 3'b101, 6'h00, 32'h80000000, 32'h7FFFFFFF, 32'd0, 0, 32'd0,
             '{32'd1, 1'b0, 32'd0, 3'b111});
        step("add_wrap0",  0, 3'b010, 6'h20, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 32'd0,
             '{32'd0, 1'b1, 32'd0, 3'b010});
        step("fn_undef",   0, 3'b010, 6'h3f, 32'd5, 32'd7, 32'd0, 0, 32'd0,
             '{32'd12, 1'b0, 32'd0, 3'b010});
        step("op_undef",   0, 3'b111, 6'h22, 32'd3, 32'd4, 32'd0, 0, 32'd0,
             '{32'd7, 1'b0, 32'd0, 3'b010});
        step("reset_mid",  1, 3'b001, 6'h00, 32'd9, 32'd2, 32'd5, 0, 32'd12, RST);
        step("post_reset", 0, 3'b001, 6'h00, 32'd9, 32'd2, 32'd5, 0, 32'd12,
             '{32'd7, 1'b0, 32'd32, 3'b110});

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rf  = (i % 2 == 0) ? 6'($urandom_range(32, 42)) : 6'($urandom);
            ra  = $urandom; rb = (i % 5 == 0) ? ra : $urandom;
            ri  = $urandom; rs = 1'($urandom); rp = $urandom;
            step("random", 0, rop, rf, ra, rb, ri, rs, rp, model(rop, rf, ra, rb, ri, rs, rp));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
